// File: rtl/core_dmem_pkg.sv
// core_dmem_pkg: RV32I load/store func3 encodings and MMIO address map for the data memory
package core_dmem_pkg;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } func3_e;
  localparam logic [31:0] CON_TX_ADDR   = 32'h1000_0000;
  localparam logic [31:0] CON_STAT_ADDR = 32'h1000_0004;
  localparam logic [31:0] MTIME_LO_ADDR = 32'h1000_0008;
  localparam logic [31:0] MTIME_HI_ADDR = 32'h1000_000C;
  localparam int          CON_DEPTH     = 4;
endpackage

// File: rtl/core_dmem_con_fifo.sv
// core_dmem_con_fifo: 4-entry byte FIFO feeding the console; head reads as 0 when empty
module core_dmem_con_fifo
  import core_dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem_q [CON_DEPTH];
  logic [7:0] mem_d [CON_DEPTH];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pop_ok, push_ok;
  assign empty = cnt_q == 3'd0;
  assign full  = cnt_q == 3'(CON_DEPTH);
  assign count = cnt_q;
  assign rdata = empty ? 8'h00 : mem_q[rp_q];
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    mem_d   = mem_q;
    if (push_ok) mem_d[wp_q] = wdata;
    wp_d    = wp_q + 2'(push_ok);
    rp_d    = rp_q + 2'(pop_ok);
    cnt_d   = cnt_q + 3'(push_ok) - 3'(pop_ok);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '{default: 8'h00};
      wp_q  <= 2'd0;
      rp_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/core_dmem_top.sv
// core_dmem_top: data RAM plus console FIFO and 64-bit mtime MMIO, single-cycle LSU bus
module core_dmem_top
  import core_dmem_pkg::*;
#(
  parameter int RAM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        bus_wen,
  input  logic        bus_ren,
  input  logic [2:0]  bus_rwtyp,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data
);
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  logic [31:0] ram [RAM_WORDS];
  logic [63:0] mtime_q, mtime_d;
  logic        ovf_q, ovf_d;
  logic        req, type_ok, sz_h, sz_w, misalign;
  logic        is_ram, is_tx, is_stat, is_lo, is_hi, wr_ok;
  logic        push_req, push, pop, fifo_full, fifo_empty;
  logic [2:0]  fifo_count;
  logic [AW-1:0] idx;
  logic [31:0] reg_val, shifted, wlanes;
  logic [3:0]  be;
  always_comb begin
    req      = bus_wen | bus_ren;
    type_ok  = bus_rwtyp inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    sz_h     = bus_rwtyp[1:0] == 2'b01;
    sz_w     = bus_rwtyp == F3_W;
    misalign = (sz_h & bus_addr[0]) | (sz_w & |bus_addr[1:0]);
    is_ram   = bus_addr < RAM_BYTES;
    is_tx    = bus_addr[31:2] == CON_TX_ADDR[31:2];
    is_stat  = bus_addr[31:2] == CON_STAT_ADDR[31:2];
    is_lo    = bus_addr[31:2] == MTIME_LO_ADDR[31:2];
    is_hi    = bus_addr[31:2] == MTIME_HI_ADDR[31:2];
    bus_err  = req & (~type_ok | misalign | ~(is_ram | is_tx | is_stat | is_lo | is_hi)
               | (bus_wen & (is_lo | is_hi) & ~sz_w));
    wr_ok    = bus_wen & ~bus_err;
    idx      = bus_addr[AW+1:2];
    reg_val  = is_ram  ? ram[idx] :
               is_stat ? {27'b0, ovf_q, fifo_count, fifo_full} :
               is_lo   ? mtime_q[31:0] :
               is_hi   ? mtime_q[63:32] : 32'h0;
    shifted  = reg_val >> {bus_addr[1:0], 3'b000};
    // bit 2 of func3 selects zero-extension (LBU/LHU)
    bus_rdata = (~req | bus_err) ? 32'h0 :
                sz_w ? reg_val :
                sz_h ? {{16{~bus_rwtyp[2] & shifted[15]}}, shifted[15:0]} :
                       {{24{~bus_rwtyp[2] & shifted[7]}}, shifted[7:0]};
    be       = sz_w ? 4'hF : sz_h ? (bus_addr[1] ? 4'hC : 4'h3) : 4'b0001 << bus_addr[1:0];
    wlanes   = sz_w ? bus_wdata : sz_h ? {2{bus_wdata[15:0]}} : {4{bus_wdata[7:0]}};
    push_req = wr_ok & is_tx;
    pop      = ~fifo_empty & con_ready;
    push     = push_req & (~fifo_full | pop);
    ovf_d    = (wr_ok & is_stat) ? 1'b0 : (push_req & ~push) ? 1'b1 : ovf_q;
    mtime_d  = (wr_ok & is_lo) ? {mtime_q[63:32], bus_wdata} :
               (wr_ok & is_hi) ? {bus_wdata, mtime_q[31:0]} : mtime_q + 64'd1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q <= 64'd0;
      ovf_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok & is_ram)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= wlanes[8*i +: 8];
  end
  core_dmem_con_fifo u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (bus_wdata[7:0]),
    .rdata (con_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign con_valid = ~fifo_empty;
endmodule
